// File: rtl/dlc_tx_flit_sched_if.sv
// Flit scheduler handshake bundle: three flit sources in, one flit stage out.
// master = the surrounding logic (sources, serializer, link control); slave = the scheduler.
// Purely a wiring container; no storage, no timing of its own.
interface dlc_tx_flit_sched_if #(
  parameter int WIDTH = 512
);
  logic             rpl_valid;
  logic [WIDTH-1:0] rpl_data;
  logic             rpl_ready;
  logic             ctl_valid;
  logic [WIDTH-1:0] ctl_data;
  logic             ctl_ready;
  logic             tl_valid;
  logic [WIDTH-1:0] tl_data;
  logic             tl_ready;
  logic             halt;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_ready;
  logic             starve_grant;

  modport master (
    output rpl_valid, rpl_data, ctl_valid, ctl_data, tl_valid, tl_data,
    output halt, out_ready,
    input  rpl_ready, ctl_ready, tl_ready,
    input  out_valid, out_data, out_src, starve_grant
  );

  modport slave (
    input  rpl_valid, rpl_data, ctl_valid, ctl_data, tl_valid, tl_data,
    input  halt, out_ready,
    output rpl_ready, ctl_ready, tl_ready,
    output out_valid, out_data, out_src, starve_grant
  );
endinterface

// File: rtl/dlc_tx_flit_sched.sv
// TX flit scheduler: replay > control > TL priority with a TL starvation override.
// Latency: 1 cycle from accept (x_ready) to out_valid; one flit per cycle when out_ready is held.
// Backpressure: output register loads only when empty or consumed, and never during halt/reset.
module dlc_tx_flit_sched #(
  parameter int WIDTH        = 512,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  dlc_tx_flit_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_RPL  = 2'b01,
    SRC_CTL  = 2'b10,
    SRC_TL   = 2'b11
  } src_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  src_e             out_src_q;
  logic [3:0]       starve_cnt_q;
  logic             starve_grant_q;

  logic             load;
  logic             starved;
  src_e             winner;
  logic [WIDTH-1:0] win_data;

  // The output stage may take a new flit only when it is empty or being drained this cycle.
  assign load    = reset_n & ~bus.halt & (bus.out_ready | ~out_valid_q);
  assign starved = (starve_cnt_q == LIMIT);

  // Arbitration: a starved TL beats everything, otherwise strict replay > control > TL.
  always_comb begin
    winner   = SRC_NONE;
    win_data = bus.tl_data;
    if (starved && bus.tl_valid) begin
      winner   = SRC_TL;
      win_data = bus.tl_data;
    end else if (bus.rpl_valid) begin
      winner   = SRC_RPL;
      win_data = bus.rpl_data;
    end else if (bus.ctl_valid) begin
      winner   = SRC_CTL;
      win_data = bus.ctl_data;
    end else if (bus.tl_valid) begin
      winner   = SRC_TL;
      win_data = bus.tl_data;
    end
  end

  // Ready is the grant itself, so accept and launch happen on the same edge.
  assign bus.rpl_ready = load && (winner == SRC_RPL);
  assign bus.ctl_ready = load && (winner == SRC_CTL);
  assign bus.tl_ready  = load && (winner == SRC_TL);

  // Output flit register, starvation counter and forced-grant pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_src_q      <= SRC_NONE;
      starve_cnt_q   <= 4'd0;
      starve_grant_q <= 1'b0;
    end else begin
      starve_grant_q <= load && (winner == SRC_TL) && starved
                        && (bus.rpl_valid || bus.ctl_valid);
      if (load) begin
        if (winner != SRC_NONE) begin
          out_valid_q <= 1'b1;
          out_data_q  <= win_data;
          out_src_q   <= winner;
        end else begin
          // Empty slot: data is left as-is so the lane sees no needless toggling.
          out_valid_q <= 1'b0;
          out_src_q   <= SRC_NONE;
        end
        if (bus.tl_valid && (winner != SRC_TL)) begin
          if (!starved) starve_cnt_q <= starve_cnt_q + 4'd1;
        end else begin
          starve_cnt_q <= 4'd0;
        end
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_src      = out_src_q;
  assign bus.starve_grant = starve_grant_q;

endmodule
